// File: rtl/axi_mem_if.sv
// AXI4 data-side bus bundle between the load/store initiator and the memory responder.
// No awsize is carried: every beat is a full 64-bit word.
interface axi_mem_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;

    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic        awready;

    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, arburst, arlen, arsize,
        input  arready,
        input  rdata, rresp, rvalid, rlast,
        output rready,
        output awaddr, awvalid, awburst, awlen,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid, arburst, arlen, arsize,
        output arready,
        output rdata, rresp, rvalid, rlast,
        input  rready,
        input  awaddr, awvalid, awburst, awlen,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by a word-addressed 64-bit memory; independent read and write FSMs.
// Define AXI_MEM_LATENCY_EN to insert LATENCY wait cycles before the first R beat and before B.
module axi_mem_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2
) (
    input  logic      clk,
    input  logic      rst,
    axi_mem_if.slave  bus
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [1:0]  FIXED  = 2'b00;
`ifdef AXI_MEM_LATENCY_EN
    localparam logic [15:0] LAT_LAST = (LATENCY > 0) ? 16'(LATENCY - 1) : 16'd0;
`endif

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA
`ifdef AXI_MEM_LATENCY_EN
        , R_WAIT
`endif
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
`ifdef AXI_MEM_LATENCY_EN
        , W_WAIT
`endif
    } w_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr >= ADDR_BASE) && (((addr - ADDR_BASE) >> 3) < DEPTH_WORDS);
    endfunction

    function automatic idx_t addr_to_idx(input logic [31:0] addr);
        return idx_t'((addr - ADDR_BASE) >> 3);
    endfunction

    // WRAP is treated as INCR; the index wraps naturally at DEPTH_WORDS.
    function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst);
        return (burst == FIXED) ? idx : idx + idx_t'(1);
    endfunction

    logic [63:0] mem_q [DEPTH_WORDS];

    r_state_e    r_state_q, r_state_d;
    idx_t        r_idx_q, r_idx_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic        r_oor_q, r_oor_d;

    w_state_e    w_state_q, w_state_d;
    idx_t        w_idx_q, w_idx_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [7:0]  w_beat_q, w_beat_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic        w_oor_q, w_oor_d;
    logic        w_err_q, w_err_d;
    logic        mem_we;

`ifdef AXI_MEM_LATENCY_EN
    logic [15:0] r_cnt_q, r_cnt_d;
    logic [15:0] w_cnt_q, w_cnt_d;
`endif

    logic unused_arsize;
    assign unused_arsize = ^bus.arsize;

    always_comb begin
        r_state_d   = r_state_q;
        r_idx_d     = r_idx_q;
        r_len_d     = r_len_q;
        r_beat_d    = r_beat_q;
        r_burst_d   = r_burst_q;
        r_oor_d     = r_oor_q;
`ifdef AXI_MEM_LATENCY_EN
        r_cnt_d     = r_cnt_q;
`endif
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = OKAY;
        bus.rlast   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                bus.arready = !rst;
                if (bus.arvalid && !rst) begin
                    r_idx_d   = addr_to_idx(bus.araddr);
                    r_len_d   = bus.arlen;
                    r_burst_d = bus.arburst;
                    r_oor_d   = !addr_in_range(bus.araddr);
                    r_beat_d  = '0;
`ifdef AXI_MEM_LATENCY_EN
                    r_cnt_d   = '0;
                    r_state_d = (LATENCY == 0) ? R_DATA : R_WAIT;
`else
                    r_state_d = R_DATA;
`endif
                end
            end
`ifdef AXI_MEM_LATENCY_EN
            R_WAIT: begin
                if (r_cnt_q == LAT_LAST) r_state_d = R_DATA;
                else                     r_cnt_d   = r_cnt_q + 16'd1;
            end
`endif
            R_DATA: begin
                // Combinational array read: a same-cycle write to this word shows up next cycle.
                bus.rvalid = 1'b1;
                bus.rdata  = r_oor_q ? 64'd0 : mem_q[r_idx_q];
                bus.rresp  = r_oor_q ? SLVERR : OKAY;
                bus.rlast  = (r_beat_q == r_len_q);
                if (bus.rready) begin
                    r_beat_d = r_beat_q + 8'd1;
                    r_idx_d  = next_idx(r_idx_q, r_burst_q);
                    if (r_beat_q == r_len_q) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_beat_d    = w_beat_q;
        w_burst_d   = w_burst_q;
        w_oor_d     = w_oor_q;
        w_err_d     = w_err_q;
`ifdef AXI_MEM_LATENCY_EN
        w_cnt_d     = w_cnt_q;
`endif
        mem_we      = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = OKAY;
        case (w_state_q)
            W_IDLE: begin
                bus.awready = !rst;
                if (bus.awvalid && !rst) begin
                    w_idx_d   = addr_to_idx(bus.awaddr);
                    w_len_d   = bus.awlen;
                    w_burst_d = bus.awburst;
                    w_oor_d   = !addr_in_range(bus.awaddr);
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid) begin
                    mem_we   = !w_oor_q;
                    w_beat_d = w_beat_q + 8'd1;
                    w_idx_d  = next_idx(w_idx_q, w_burst_q);
                    if (bus.wlast != (w_beat_q == w_len_q)) w_err_d = 1'b1;
                    // The burst length comes from AWLEN; a misplaced WLAST only flags an error.
                    if (w_beat_q == w_len_q) begin
`ifdef AXI_MEM_LATENCY_EN
                        w_cnt_d   = '0;
                        w_state_d = (LATENCY == 0) ? W_RESP : W_WAIT;
`else
                        w_state_d = W_RESP;
`endif
                    end
                end
            end
`ifdef AXI_MEM_LATENCY_EN
            W_WAIT: begin
                if (w_cnt_q == LAT_LAST) w_state_d = W_RESP;
                else                     w_cnt_d   = w_cnt_q + 16'd1;
            end
`endif
            W_RESP: begin
                bus.bvalid = 1'b1;
                bus.bresp  = (w_oor_q || w_err_q) ? SLVERR : OKAY;
                if (bus.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
        end
    end

    // Burst bookkeeping is only consumed after an address handshake reloads it.
    always_ff @(posedge clk) begin
        r_idx_q   <= r_idx_d;
        r_len_q   <= r_len_d;
        r_beat_q  <= r_beat_d;
        r_burst_q <= r_burst_d;
        r_oor_q   <= r_oor_d;
        w_idx_q   <= w_idx_d;
        w_len_q   <= w_len_d;
        w_beat_q  <= w_beat_d;
        w_burst_q <= w_burst_d;
        w_oor_q   <= w_oor_d;
        w_err_q   <= w_err_d;
`ifdef AXI_MEM_LATENCY_EN
        r_cnt_q   <= r_cnt_d;
        w_cnt_q   <= w_cnt_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.wstrb[i]) mem_q[w_idx_q][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 full responder that backs the data-memory port with a word-addressed 64-bit SRAM model, serving the load/store initiator's read and write bursts. Read and write channels are independent state machines sharing one memory array, so a read burst and a write burst can be in flight simultaneously. The block is the simulation/FPGA memory endpoint on the data-side bus and can also model response latency to exercise initiator wait states.

## Interface
- ADDR_BASE, 32'h8000_0000, byte address mapped to word 0
- DEPTH_WORDS, 4096, number of 64-bit words (power of two)
- LATENCY, 2, wait cycles before first R beat and before B (used only with AXI_MEM_LATENCY_EN)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- araddr  in  32  read start byte address
- arvalid  in  1  read address valid
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP (handled as INCR)
- arlen  in  8  beats minus one
- arsize  in  3  ignored; every beat is 8 bytes
- arready  out  1  read address accept
- rdata  out  64  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rlast  out  1  final beat of read burst
- rready  in  1  initiator accepts R beat
- awaddr  in  32  write start byte address
- awvalid  in  1  write address valid
- awburst  in  2  as arburst
- awlen  in  8  beats minus one
- awready  out  1  write address accept
- wdata  in  64  write data
- wstrb  in  8  byte enables, bit i -> wdata[8i+7:8i]
- wlast  in  1  initiator's last-beat marker
- wvalid  in  1  write data valid
- wready  out  1  write data accept
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  initiator accepts B

## Operation
- Word index = (addr - ADDR_BASE) >> 3, low 3 address bits ignored. Address is out of range if addr < ADDR_BASE or index >= DEPTH_WORDS.
- Read FSM: R_IDLE -> (arvalid&arready) latch index, arlen, arburst, range flag, beat=0 -> R_WAIT (macro on) or R_DATA. R_WAIT counts LATENCY cycles then R_DATA. R_DATA: rvalid=1, rdata=mem[index] (0 if out of range), rresp=SLVERR if out of range else OKAY, rlast=(beat==arlen). On rvalid&rready: beat+1; index+1 modulo DEPTH_WORDS for INCR/WRAP, unchanged for FIXED; if rlast -> R_IDLE.
- Write FSM: W_IDLE -> (awvalid&awready) latch index, awlen, awburst, range flag, beat=0, err=0 -> W_DATA. W_DATA: wready=1; on wvalid&wready write each byte with wstrb set (no write if out of range), advance index as for reads. err set if wlast != (beat==awlen). Burst ends on own count (beat==awlen), not on wlast -> W_WAIT (macro on) or W_RESP.
- W_RESP: bvalid=1, bresp=SLVERR if out of range or err else OKAY; held stable until bready, then W_IDLE.
- arready=1 only in R_IDLE, awready=1 only in W_IDLE; both 0 while rst is high.
- rresp/bresp/rdata/rlast are 0 whenever the matching valid is 0.
- Same-word read and write in one cycle: rdata shows pre-write value that cycle, new value on the following cycle if beat not yet accepted.
- Reset mid-burst: both FSMs return to idle at next edge, in-flight burst abandoned, memory contents retained.

## Timing
- Reset values: arready=0, awready=0 during rst; first cycle after rst low: arready=1, awready=1; rvalid, rlast, wready, bvalid = 0; rresp, bresp = 00; rdata = 0.
- AR handshake at cycle N -> first rvalid at N+1 (N+1+LATENCY with macro).
- Sustained R throughput 1 beat/cycle with rready held high; rvalid and rdata hold while rready low.
- AW handshake at N -> wready at N+1; writes take effect at the handshake edge.
- Last W handshake at N -> bvalid at N+1 (N+1+LATENCY with macro).
- No new AR accepted until the R burst's last handshake cycle has passed; same for AW/B.

## Configuration
- AXI_MEM_LATENCY_EN defined: R_WAIT and W_WAIT states present, LATENCY-cycle counter inserted before first R beat and before B.
- Undefined: wait states and counter compiled out, LATENCY ignored, minimum latency per Timing.

## Test plan
- Write awaddr=0x8000_0010, awlen=1, wdata 0x1111..., 0x2222..., wstrb=0xFF, bready=1 -> bvalid one cycle after beat 2, bresp=00; read same, arlen=1 -> rdata 0x1111... then 0x2222..., rlast on beat 2.
- Partial strobe: mem word 0 = 0, write 0xAABB_CCDD_EEFF_0011 wstrb=0x0F -> readback 0x0000_0000_EEFF_0011.
- Backpressure: rready low for 3 cycles mid-burst -> rvalid, rdata, rlast stable; bready low 5 cycles -> bvalid, bresp stable.
- araddr=0x7FFF_FFF8 arlen=0 -> rresp=10, rdata=0; matching write -> bresp=10, memory unchanged.
- Concurrent AR and AW in same cycle to different words -> both accepted, both complete without stall; with AXI_MEM_LATENCY_EN and LATENCY=2 first rvalid at N+3.
- rst asserted mid read burst -> next cycle rvalid=0, arready=0 until rst low, then arready=1 and a fresh burst completes correctly.
